// File: rtl/l1icache_assoc.sv
// Set-associative L1 instruction cache with per-set round-robin replacement,
// whole-line MMU refill, uncached MMIO pass-through buffer and invalidate-all.
module l1icache_assoc #(
  parameter int          WAYS       = 2,
  parameter int          SETS       = 256,
  parameter int          LINE_WORDS = 8,
  parameter logic [31:0] MMIO_MASK  = 32'hF000_0000,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     l1_read,
  input  logic [31:0]              l1_addr,
  output logic [31:0]              l1_data_o,
  output logic                     miss_stall,
  output logic                     invalid_stall,
  input  logic                     out_req_stall,
  output logic                     l1_mmu_req_read,
  output logic [31:0]              l1_mmu_req_addr,
  input  logic                     mmu_l1_done,
  input  logic [LINE_WORDS*32-1:0] mmu_l1_read_data,
  input  logic                     is_sync_ins,
  input  logic [4:0]               sync_type
);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = LINE_WORDS * 32;

  typedef enum logic [2:0] {IDLE, REFILL, MMIO, INVAL, DONE} state_t;
  state_t state, state_next;

  logic [LINE_W-1:0] line_mem [WAYS][SETS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [SETS-1:0]   valid    [WAYS];
  logic [WAY_W-1:0]  rr       [SETS];
  logic [IDX_W-1:0]  inv_cnt;
  logic              buf_valid;
  logic [31:0]       buf_addr;
  logic [31:0]       buf_data;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-3:0]  word_sel;
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  rr_inc;
  logic              is_mmio, buf_match, inv_req;
  logic              cached_miss, mmio_miss, refill_done, mmio_done;

  assign tag      = l1_addr[31:32-TAG_W];
  assign idx      = l1_addr[OFF_W+IDX_W-1:OFF_W];
  assign word_sel = l1_addr[OFF_W-1:2];
  assign fill_tag = l1_mmu_req_addr[31:32-TAG_W];
  assign fill_idx = l1_mmu_req_addr[OFF_W+IDX_W-1:OFF_W];

  assign is_mmio     = (l1_addr & MMIO_MASK) == MMIO_BASE;
  assign buf_match   = buf_valid && (buf_addr == l1_addr);
  assign inv_req     = is_sync_ins && (sync_type == 5'b00001);
  assign cached_miss = l1_read && !is_mmio && !hit;
  assign mmio_miss   = l1_read && is_mmio && !buf_match;
  assign refill_done = (state == REFILL) && mmu_l1_done;
  assign mmio_done   = (state == MMIO) && mmu_l1_done;

  // Fetch handshake: a fetch with l1_read=1 is served in the cycle where
  // miss_stall=0 (and no invalidate stall); until then l1_addr stays stable.
  assign miss_stall    = cached_miss || mmio_miss;
  assign invalid_stall = inv_req && (state != DONE);

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w][idx] && (tag_mem[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line  = line_mem[hit_way][idx];
  assign l1_data_o = is_mmio ? buf_data : hit_line[{word_sel, 5'd0} +: 32];

  // Victim: lowest invalid way first, otherwise the set's round-robin pointer.
  always_comb begin
    victim = rr[fill_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][fill_idx]) victim = WAY_W'(w);
    end
  end

  assign rr_inc = (rr[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr[fill_idx] + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (inv_req)          state_next = INVAL;
        else if (cached_miss) state_next = REFILL;
        else if (mmio_miss)   state_next = MMIO;
      end
      REFILL, MMIO: if (mmu_l1_done) state_next = IDLE;
      INVAL:  if (inv_cnt == IDX_W'(SETS - 1)) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      l1_mmu_req_read <= 1'b0;
      l1_mmu_req_addr <= '0;
      inv_cnt         <= '0;
    end else begin
      state           <= state_next;
      l1_mmu_req_read <= (state_next == REFILL) || (state_next == MMIO);
      if ((state == IDLE) && !inv_req) begin
        if (cached_miss)    l1_mmu_req_addr <= {l1_addr[31:OFF_W], {OFF_W{1'b0}}};
        else if (mmio_miss) l1_mmu_req_addr <= l1_addr;
      end
      if (state == INVAL) inv_cnt <= inv_cnt + 1'b1;
      else                inv_cnt <= '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      if (refill_done) begin
        valid[victim][fill_idx] <= 1'b1;
        rr[fill_idx]            <= rr_inc;
      end
      if (state == INVAL) begin
        for (int w = 0; w < WAYS; w++) valid[w][inv_cnt] <= 1'b0;
        rr[inv_cnt] <= '0;
      end
      // A held pipeline keeps the MMIO word even if the address wanders.
      if ((l1_addr != buf_addr) && !out_req_stall) buf_valid <= 1'b0;
      if (mmio_done) begin
        buf_valid <= 1'b1;
        buf_addr  <= l1_mmu_req_addr;
        buf_data  <= mmu_l1_read_data[31:0];
      end
    end
  end

  // Line storage carries no reset; only the valid bits qualify it.
  always_ff @(posedge sys_clk) begin
    if (refill_done) begin
      line_mem[victim][fill_idx] <= mmu_l1_read_data;
      tag_mem[victim][fill_idx]  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_l1icache_assoc.sv
// Directed bench for l1icache_assoc (WAYS=2, SETS=4, LINE_WORDS=8): fetch
// expectations go through a scoreboard queue popped by a monitor.
module tb_l1icache_assoc;
  logic         sys_clk;
  logic         rst_n;
  logic         l1_read;
  logic [31:0]  l1_addr;
  logic [31:0]  l1_data_o;
  logic         miss_stall;
  logic         invalid_stall;
  logic         out_req_stall;
  logic         l1_mmu_req_read;
  logic [31:0]  l1_mmu_req_addr;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  logic         is_sync_ins;
  logic [4:0]   sync_type;

  logic [31:0] exp_q[$];
  logic [31:0] req_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int mmu_lat = 3;
  bit mmu_abort;

  l1icache_assoc #(.WAYS(2), .SETS(4), .LINE_WORDS(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .l1_read(l1_read), .l1_addr(l1_addr),
    .l1_data_o(l1_data_o), .miss_stall(miss_stall), .invalid_stall(invalid_stall),
    .out_req_stall(out_req_stall), .l1_mmu_req_read(l1_mmu_req_read),
    .l1_mmu_req_addr(l1_mmu_req_addr), .mmu_l1_done(mmu_l1_done),
    .mmu_l1_read_data(mmu_l1_read_data), .is_sync_ins(is_sync_ins),
    .sync_type(sync_type)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- memory image ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] base;
    logic [31:0] i;
    base = {a[31:5], 5'b0};
    i    = {29'd0, a[4:2]};
    if (a == 32'hF000_0010) return 32'h0000_1234;
    if (a == 32'hF000_0014) return 32'h0000_5678;
    case (base)
      32'h0000_0100: return 32'hA0 + i;
      32'h0000_0000: return 32'hB0 + i;
      32'h0000_0080: return 32'hC0 + i;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- MMU responder ----------------
  initial begin
    mmu_l1_done = 1'b0;
    mmu_l1_read_data = '0;
    forever begin
      @(negedge sys_clk);
      if (rst_n && l1_mmu_req_read) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_req: got %h required none", l1_mmu_req_addr);
        end else begin
          chk("req_addr", l1_mmu_req_addr, req_q.pop_front());
        end
        mmu_abort = 1'b0;
        for (int i = 0; i < mmu_lat && !mmu_abort; i++) begin
          @(posedge sys_clk);
          #1;
          if (!l1_mmu_req_read) mmu_abort = 1'b1;
        end
        if (!mmu_abort) begin
          for (int i = 0; i < 8; i++)
            mmu_l1_read_data[i*32 +: 32] = mem_word(l1_mmu_req_addr + 32'(4 * i));
          mmu_l1_done = 1'b1;
          @(posedge sys_clk);
          #1;
          mmu_l1_done = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    if (rst_n && l1_read && !miss_stall && !invalid_stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_fetch: got %h required none", l1_data_o);
      end else begin
        chk("fetch_data", l1_data_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input bit miss);
    int  st;
    bit  ok;
    l1_addr = a;
    l1_read = 1'b1;
    exp_q.push_back(d);
    if (miss) req_q.push_back(a[31:28] == 4'hF ? a : {a[31:5], 5'b0});
    st = 0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge sys_clk);
      if (!miss_stall && !invalid_stall) ok = 1'b1;
      else st++;
    end
    chk("fetch_served", 32'(ok), 32'd1);
    chk("stall_cycles", 32'(st), miss ? 32'(mmu_lat + 2) : 32'd0);
    @(posedge sys_clk);
    #1;
    l1_read = 1'b0;
  endtask

  task automatic hold_fetch(input logic [31:0] a, input logic [31:0] d, input int n);
    out_req_stall = 1'b1;
    l1_addr = a;
    l1_read = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(d);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      chk("hold_no_stall", 32'(miss_stall), 32'd0);
      @(posedge sys_clk);
      #1;
    end
    l1_read = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int cnt;
  initial begin
    rst_n = 1'b0;
    l1_read = 1'b0;
    l1_addr = '0;
    out_req_stall = 1'b0;
    is_sync_ins = 1'b0;
    sync_type = '0;
    cycles(3);
    rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_req_read", 32'(l1_mmu_req_read), 32'd0);
    chk("rst_req_addr", l1_mmu_req_addr, 32'd0);
    chk("rst_miss_stall", 32'(miss_stall), 32'd0);
    chk("rst_inv_stall", 32'(invalid_stall), 32'd0);
    cycles(1);

    // Basic miss then hits in the same line
    fetch(32'h100, 32'hA0, 1);
    fetch(32'h104, 32'hA1, 0);
    fetch(32'h11C, 32'hA7, 0);

    // Reset two cycles into a refill
    mmu_lat = 20;
    l1_addr = 32'h040;
    l1_read = 1'b1;
    req_q.push_back(32'h040);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #2;
    rst_n = 1'b0;
    l1_read = 1'b0;
    #1;
    chk("async_req_drop", 32'(l1_mmu_req_read), 32'd0);
    chk("async_addr_clr", l1_mmu_req_addr, 32'd0);
    cycles(3);
    rst_n = 1'b1;
    mmu_lat = 3;
    cycles(1);
    fetch(32'h040, 32'h5A5A_0040, 1);

    // Conflict eviction in set 0 with round-robin
    fetch(32'h000, 32'hB0, 1);
    fetch(32'h080, 32'hC0, 1);
    fetch(32'h100, 32'hA0, 1);
    fetch(32'h084, 32'hC1, 0);
    fetch(32'h108, 32'hA2, 0);
    fetch(32'h008, 32'hB2, 1);
    fetch(32'h104, 32'hA1, 0);
    fetch(32'h084, 32'hC1, 1);
    fetch(32'h010, 32'hB4, 0);

    // Non-invalidate sync type is ignored
    is_sync_ins = 1'b1;
    sync_type = 5'b00010;
    @(negedge sys_clk);
    chk("sync_other_type", 32'(invalid_stall), 32'd0);
    cycles(1);

    // Invalidate-all
    sync_type = 5'b00001;
    @(negedge sys_clk);
    chk("inv_req_cycle", 32'(invalid_stall), 32'd1);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (!invalid_stall) break;
      cnt++;
    end
    chk("inval_cycles", 32'(cnt), 32'd4);
    cycles(1);
    is_sync_ins = 1'b0;
    sync_type = '0;
    fetch(32'h014, 32'hB5, 1);
    fetch(32'h044, 32'h5A5A_0044, 1);
    fetch(32'h10C, 32'hA3, 1);

    // MMIO pass-through buffer
    fetch(32'hF000_0010, 32'h1234, 1);
    hold_fetch(32'hF000_0010, 32'h1234, 5);
    l1_addr = 32'h200;
    cycles(2);
    l1_addr = 32'hF000_0010;
    out_req_stall = 1'b0;
    fetch(32'hF000_0010, 32'h1234, 0);
    fetch(32'hF000_0014, 32'h5678, 1);
    fetch(32'hF000_0010, 32'h1234, 1);

    // Invalidate raised while a refill is in flight
    l1_addr = 32'h0C0;
    l1_read = 1'b1;
    req_q.push_back(32'h0C0);
    cycles(1);
    is_sync_ins = 1'b1;
    sync_type = 5'b00001;
    l1_read = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge sys_clk);
      if (!invalid_stall) break;
      cnt++;
    end
    chk("inv_during_refill", 32'(cnt), 32'd9);
    chk("req_done_by_done", 32'(l1_mmu_req_read), 32'd0);
    cycles(1);
    is_sync_ins = 1'b0;
    sync_type = '0;
    fetch(32'h0C4, 32'h5A5A_00C4, 1);

    cycles(3);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
